// File: rtl/eth_fcs_checker.sv
// Receive-side Ethernet FCS checker.
// Runs CRC-32 over every frame byte including the FCS and compares the final
// register with the Ethernet residue. The payload is forwarded through a
// 4-byte delay line, so the trailing FCS bytes are never emitted. Per-frame
// status and payload length are reported with a one-cycle frame_done pulse.
module eth_fcs_checker #(
  parameter int MAX_LEN = 1518
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        rx_sof,
  input  logic        rx_eof,
  output logic [7:0]  out_data,
  output logic        out_valid,
  output logic        out_sof,
  output logic        frame_done,
  output logic        frame_ok,
  output logic        crc_err,
  output logic        len_err,
  output logic        abort,
  output logic [15:0] out_len
);

  typedef enum logic {IDLE, RX} state_t;

  localparam logic [31:0] CRC_POLY    = 32'h04C11DB7;
  localparam logic [31:0] CRC_PRESET  = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;
  localparam logic [15:0] MAX_LEN_W   = 16'(MAX_LEN);

  // Byte-parallel CRC-32 step; data bits enter LSB first.
  function automatic logic [31:0] crc_update(input logic [31:0] crc, input logic [7:0] d);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[31] ^ d[i]) c = {c[30:0], 1'b0} ^ CRC_POLY;
      else              c = {c[30:0], 1'b0};
    end
    return c;
  endfunction

  state_t      state_q, state_d;
  logic [31:0] crc_q, crc_d, crc_next;
  logic [15:0] count_q, count_d, count_inc;
  logic [2:0]  dl_cnt_q, dl_cnt_d;
  logic        sof_pend_q, sof_pend_d;
  logic [7:0]  dl_q [4];

  logic [7:0]  out_data_d;
  logic        out_valid_d, out_sof_d;
  logic        fin, fin_abort, fin_crc_err, fin_len_err;
  logic [15:0] fin_count, out_len_d;

  // A start-of-frame byte always restarts the CRC from the preset.
  assign crc_next  = crc_update(rx_sof ? CRC_PRESET : crc_q, rx_data);
  assign count_inc = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;

  // Next-state, delay-line bookkeeping and finish decision.
  always_comb begin
    // NOTE: every variable gets a default here so no path infers a latch.
    state_d     = state_q;
    crc_d       = crc_q;
    count_d     = count_q;
    dl_cnt_d    = dl_cnt_q;
    sof_pend_d  = sof_pend_q;
    out_data_d  = '0;
    out_valid_d = 1'b0;
    out_sof_d   = 1'b0;
    fin         = 1'b0;
    fin_abort   = 1'b0;
    fin_count   = '0;

    case (state_q)
      IDLE: begin
        if (rx_valid && rx_sof) begin
          state_d    = RX;
          crc_d      = crc_next;
          count_d    = 16'd1;
          dl_cnt_d   = 3'd1;
          sof_pend_d = 1'b1;
          if (rx_eof) begin
            fin       = 1'b1;
            fin_count = 16'd1;
          end
        end
      end
      RX: begin
        if (rx_valid) begin
          if (rx_sof) begin
            // Old frame is cut short; this byte opens the next one.
            fin        = 1'b1;
            fin_abort  = 1'b1;
            fin_count  = count_q;
            crc_d      = crc_next;
            count_d    = 16'd1;
            dl_cnt_d   = 3'd1;
            sof_pend_d = 1'b1;
          end else begin
            crc_d   = crc_next;
            count_d = count_inc;
            if (dl_cnt_q == 3'd4) begin
              out_valid_d = 1'b1;
              out_data_d  = dl_q[3];
              out_sof_d   = sof_pend_q;
              sof_pend_d  = 1'b0;
            end else begin
              dl_cnt_d = dl_cnt_q + 3'd1;
            end
            if (rx_eof) begin
              fin       = 1'b1;
              fin_count = count_inc;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // An eof byte closes whatever frame it belongs to; the delay line is dropped.
    if (fin && rx_eof) begin
      state_d    = IDLE;
      crc_d      = CRC_PRESET;
      count_d    = '0;
      dl_cnt_d   = '0;
      sof_pend_d = 1'b0;
    end
  end

  // Status evaluated at the finishing edge; crc check is meaningless on abort.
  always_comb begin
    fin_len_err = (fin_count < 16'd5) || (fin_count > MAX_LEN_W);
    fin_crc_err = !fin_abort && (crc_next != CRC_RESIDUE);
    out_len_d   = out_len;
    if (fin) out_len_d = (fin_count >= 16'd4) ? fin_count - 16'd4 : 16'd0;
  end

  // Control state and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state_q    <= IDLE;
      crc_q      <= CRC_PRESET;
      count_q    <= '0;
      dl_cnt_q   <= '0;
      sof_pend_q <= 1'b0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      out_sof    <= 1'b0;
      frame_done <= 1'b0;
      frame_ok   <= 1'b0;
      crc_err    <= 1'b0;
      len_err    <= 1'b0;
      abort      <= 1'b0;
      out_len    <= '0;
    end else begin
      state_q    <= state_d;
      crc_q      <= crc_d;
      count_q    <= count_d;
      dl_cnt_q   <= dl_cnt_d;
      sof_pend_q <= sof_pend_d;
      out_data   <= out_data_d;
      out_valid  <= out_valid_d;
      out_sof    <= out_sof_d;
      frame_done <= fin;
      frame_ok   <= fin && !fin_len_err && !fin_crc_err && !fin_abort;
      crc_err    <= fin && fin_crc_err;
      len_err    <= fin && fin_len_err;
      abort      <= fin_abort;
      out_len    <= out_len_d;
    end
  end

  // Delay-line storage; dl_q[3] is the oldest byte.
  always_ff @(posedge clk) begin
    // NOTE: the byte storage is not reset; dl_cnt_q marks it empty, so its
    // contents are never observed before being overwritten.
    if (rx_valid) begin
      dl_q[0] <= rx_data;
      dl_q[1] <= dl_q[0];
      dl_q[2] <= dl_q[1];
      dl_q[3] <= dl_q[2];
    end
  end

endmodule
